// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock supervisor: FSM encoding, counter widths, parameter defaults.
package lock_pkg;

  localparam int unsigned FAIL_W  = 8;
  localparam int unsigned LOCK_W  = 4;
  localparam int unsigned TIMER_W = 16;

  localparam int unsigned LG_MAX_FAIL       = 3;
  localparam int unsigned LG_LOCKOUT_CYCLES = 16;
  localparam int unsigned LG_MAX_LOCKOUTS   = 2;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'b00,
    ST_LOCKOUT = 2'b01,
    ST_ALARM   = 2'b10
  } lg_state_e;

endpackage

// File: rtl/lock_edge_det.sv
// Single-bit rising-edge detector; history resets to 1 so a level already high at reset release is not an edge.
module lock_edge_det (
  input  logic clock,
  input  logic resetphase,
  input  logic sig,
  output logic rise_c
);

  logic hist;

  always_ff @(posedge clock) begin
    if (resetphase) hist <= 1'b1;
    else            hist <= sig;
  end

  assign rise_c = sig & ~hist;

endmodule

// File: rtl/lock_guard.sv
// Supervisor for the sequence-detector lock: counts failed attempts, enforces timed lockouts,
// escalates to a sticky alarm, and gates the key source while blocked.
module lock_guard
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAIL       = LG_MAX_FAIL,
  parameter int unsigned LOCKOUT_CYCLES = LG_LOCKOUT_CYCLES,
  parameter int unsigned MAX_LOCKOUTS   = LG_MAX_LOCKOUTS
) (
  input  logic               clock,
  input  logic               resetphase,
  input  logic               det,
  input  logic               k,
  input  logic               error,
  output logic               seq_block,
  output logic               grant,
  output logic               lockout,
  output logic               alarm,
  output logic [FAIL_W-1:0]  fail_cnt,
  output logic [LOCK_W-1:0]  lockout_cnt,
  output logic [1:0]         state_o
);

  localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
  localparam logic [LOCK_W-1:0]  LOCK_MAX   = LOCK_W'(MAX_LOCKOUTS);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  logic det_ev, k_ev, err_ev;

  lg_state_e          state_q, state_d;
  logic [FAIL_W-1:0]  fail_d;
  logic [LOCK_W-1:0]  lock_d, lock_inc;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               grant_d;

  lock_edge_det u_det_edge (.clock(clock), .resetphase(resetphase), .sig(det),   .rise_c(det_ev));
  lock_edge_det u_k_edge   (.clock(clock), .resetphase(resetphase), .sig(k),     .rise_c(k_ev));
  lock_edge_det u_err_edge (.clock(clock), .resetphase(resetphase), .sig(error), .rise_c(err_ev));

  // Saturating lockout tally so a wide count can never wrap past the alarm threshold.
  assign lock_inc = (lockout_cnt >= LOCK_MAX) ? LOCK_MAX : lockout_cnt + LOCK_W'(1);

  // Next-state and counter logic; an error always outranks a simultaneous unlock.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_cnt;
    lock_d  = lockout_cnt;
    timer_d = timer;
    grant_d = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (err_ev) begin
          if (fail_cnt >= FAIL_LAST) begin
            fail_d = '0;
            lock_d = lock_inc;
            if (lock_inc >= LOCK_MAX) begin
              state_d = ST_ALARM;
            end else begin
              state_d = ST_LOCKOUT;
              timer_d = TIMER_LOAD;
            end
          end else begin
            fail_d = fail_cnt + FAIL_W'(1);
          end
        end else if (det_ev || k_ev) begin
          grant_d = 1'b1;
          fail_d  = '0;
          lock_d  = '0;
        end
      end
      ST_LOCKOUT: begin
        if (timer == '0) state_d = ST_ARMED;
        else             timer_d = timer - TIMER_W'(1);
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: begin
        state_d = ST_ARMED;
        fail_d  = '0;
        lock_d  = '0;
        timer_d = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they align with state_o.
  always_ff @(posedge clock) begin
    if (resetphase) begin
      state_q     <= ST_ARMED;
      fail_cnt    <= '0;
      lockout_cnt <= '0;
      timer       <= '0;
      grant       <= 1'b0;
      seq_block   <= 1'b0;
      lockout     <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_cnt    <= fail_d;
      lockout_cnt <= lock_d;
      timer       <= timer_d;
      grant       <= grant_d;
      seq_block   <= (state_d != ST_ARMED);
      lockout     <= (state_d == ST_LOCKOUT);
      alarm       <= (state_d == ST_ALARM);
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/lock_guard.md
Name: lock_guard

Overview:
- Downstream supervisor for the sequence-detector lock. Consumes its det, k and error outputs.
- Counts consecutive wrong-sequence attempts and enforces a timed lockout after MAX_FAIL failures.
- Escalates to a sticky alarm after MAX_LOCKOUTS consecutive lockouts.
- Drives seq_block back to the stimulus source so the serial key input is gated while locked out.

Parameters:
- MAX_FAIL, 3: error events in ARMED that trigger a lockout (range 1..255).
- LOCKOUT_CYCLES, 16: clock cycles spent in LOCKOUT (range 1..65535).
- MAX_LOCKOUTS, 2: consecutive lockouts that trigger ALARM; a successful unlock clears the tally (range 1..15).

Ports:
- clock  in  1  single system clock, rising edge
- resetphase  in  1  synchronous, active-high reset
- det  in  1  detector "sequence matched" indication
- k  in  1  detector lock state: 1 = unlocked, 0 = locked
- error  in  1  detector "wrong sequence" indication
- seq_block  out  1  1 = source must hold seq idle (LOCKOUT or ALARM)
- grant  out  1  one-cycle pulse on an accepted unlock
- lockout  out  1  1 while in LOCKOUT
- alarm  out  1  sticky; 1 in ALARM
- fail_cnt  out  8  consecutive error events counted in ARMED
- lockout_cnt  out  4  consecutive lockouts since last grant or reset
- state_o  out  2  encoded FSM state, for debug and bench

Behaviour:
- Single clock domain. All logic updates on rising edge of clock. Reset is synchronous and active-high on resetphase.
- All outputs are registered. Each response appears on the edge after the input edge is sampled (1-cycle latency).
- Edge detection:
  - det_r and err_r register det and error.
  - det_ev = det & ~det_r; err_ev = error & ~err_r.
  - det_r and err_r reset to 1, so an input already high at reset release produces no event.
- k_ev = k rising edge, detected the same way. A grant requires det_ev, or k_ev when no det_ev occurs in the same cycle.
- Reset values: state = ARMED; all counters = 0; timer = 0; seq_block = lockout = alarm = grant = 0; fail_cnt = 0; lockout_cnt = 0.
- Reset mid-operation, including from ALARM: return to the reset values on the next edge.
- FSM encoding: ARMED = 2'b00, LOCKOUT = 2'b01, ALARM = 2'b10. 2'b11 is illegal and recovers to ARMED with counters cleared.
- ARMED:
  - err_ev with fail_cnt < MAX_FAIL-1: fail_cnt increments.
  - err_ev with fail_cnt == MAX_FAIL-1: fail_cnt clears and lockout_cnt increments.
    - If the new lockout_cnt == MAX_LOCKOUTS, go to ALARM.
    - Otherwise go to LOCKOUT and load timer = LOCKOUT_CYCLES-1.
  - Grant event with no err_ev: grant pulses for 1 cycle; fail_cnt and lockout_cnt clear.
  - err_ev and det_ev in the same cycle: the error wins and no grant is issued.
- LOCKOUT:
  - seq_block = 1 and lockout = 1.
  - The timer decrements every cycle. det, k and error events are ignored and no counter changes.
  - At timer == 0, on the next edge: go to ARMED, with seq_block and lockout deasserting on that edge.
  - The lockout therefore lasts exactly LOCKOUT_CYCLES cycles.
- ALARM:
  - seq_block = 1 and alarm = 1. All inputs are ignored.
  - Leaves only on resetphase.
- Saturation:
  - fail_cnt never exceeds MAX_FAIL-1.
  - lockout_cnt saturates at MAX_LOCKOUTS.
  - timer is 16 bits and never wraps; it is only loaded on LOCKOUT entry.

Decomposition:
- Shared package lock_pkg holds:
  - state typedef and the three encodings;
  - default constants LG_MAX_FAIL, LG_LOCKOUT_CYCLES, LG_MAX_LOCKOUTS;
  - counter widths (8, 4, 16).
- One natural sub-module: lock_edge_det. It is a single-bit rising-edge detector with reset-to-1 history and is instantiated three times (det, k, error).
- FSM, counters and timer stay in lock_guard.

Test Plan:
- Reset release with error already held high -> no err_ev. fail_cnt stays 0, state_o = 00, all outputs 0.
- Three error pulses in ARMED, 40 cycles apart (defaults) -> fail_cnt goes 1, 2, then 0. On the third pulse: lockout = seq_block = 1, lockout_cnt = 1, state_o = 01 for exactly 16 cycles, then back to 00.
- Inside LOCKOUT, pulse error and det -> no grant, fail_cnt stays 0, timer unaffected. Exit still occurs at cycle 16.
- Two errors, then a det pulse -> grant is high for 1 cycle, one cycle after det rises. fail_cnt = 0 and lockout_cnt = 0.
- det and error rising in the same cycle with fail_cnt = 2 -> no grant; LOCKOUT is entered.
- Six errors with no grant (defaults) -> the second lockout trigger goes to ALARM: alarm = 1, state_o = 10, lockout_cnt = 2. The bench holds for 100 cycles and alarm stays 1. Then resetphase = 1 for 1 cycle -> all outputs 0, state_o = 00.
